// File: rtl/a2d_rr_sampler.sv
// Round-robin A2D front end: one two-transaction SPI conversion per nxt request,
// visiting channels 0,4,5,6. Define MISO_SYNC_EN to pass MISO through a 2-flop synchronizer.
module a2d_rr_sampler #(
    parameter int unsigned SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt
);

    localparam int unsigned W    = SCLK_DIV_W;
    localparam int unsigned CW   = W + 5;
    localparam int unsigned HALF = 1 << (W - 1);

    localparam logic [CW-1:0]  TXN_LAST = CW'(34 * HALF - 1);
    localparam logic [CW-1:0]  GAP_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0]  BITS_LO  = CW'(HALF);
    localparam logic [CW-1:0]  BITS_HI  = CW'(33 * HALF);
    localparam logic [W+3:0]   P_OFS    = (W + 4)'(HALF);

`ifdef MISO_SYNC_EN
    // Sample two cycles after the SCLK rise to line up with the synchronizer delay.
    localparam logic [W-2:0] SMP_OFS = (W - 1)'(2);
`else
    localparam logic [W-2:0] SMP_OFS = '0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        GAP,
        READ
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      rr;
    logic [11:0]     rx;
    logic [2:0]      chnl;
    logic [15:0]     cmd;
    logic            in_txn_nxt;
    logic            bits_nxt;
    logic [W+3:0]    p_nxt;
    logic [W+3:0]    p_cur;
    logic            sclk_nxt;
    logic            fall_nxt;
    logic            mosi_nxt;
    logic            sample;
    logic            done;
    logic            miso_smp;

`ifdef MISO_SYNC_EN
    logic miso_s1, miso_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= MISO;
            miso_s2 <= miso_s1;
        end
    end

    assign miso_smp = miso_s2;
`else
    assign miso_smp = MISO;
`endif

    always_comb begin
        chnl = 3'd0;
        case (rr)
            2'd0: chnl = 3'd0;
            2'd1: chnl = 3'd4;
            2'd2: chnl = 3'd5;
            2'd3: chnl = 3'd6;
            default: chnl = 3'd0;
        endcase
        cmd = {2'b00, chnl, 11'h000};
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (nxt) state_nxt = CMD;
            end
            CMD: begin
                if (cnt == TXN_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = READ;
                    cnt_nxt   = '0;
                end
            end
            READ: begin
                if (cnt == TXN_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done      = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // SPI pins are registered, so decode the position of the coming cycle.
    always_comb begin
        in_txn_nxt = (state_nxt == CMD) || (state_nxt == READ);
        bits_nxt   = in_txn_nxt && (cnt_nxt >= BITS_LO) && (cnt_nxt < BITS_HI);
        p_nxt      = cnt_nxt[W+3:0] - P_OFS;
        sclk_nxt   = !(bits_nxt && !p_nxt[W-1]);
        fall_nxt   = bits_nxt && !p_nxt[W-1] && (p_nxt[W-2:0] == '0);
        mosi_nxt   = MOSI;
        if (!in_txn_nxt)
            mosi_nxt = 1'b0;
        else if (fall_nxt)
            mosi_nxt = cmd[4'd15 - p_nxt[W+3:W]];
    end

    always_comb begin
        p_cur  = cnt[W+3:0] - P_OFS;
        sample = (state == READ) && (cnt >= BITS_LO) && (cnt < BITS_HI)
                 && p_cur[W-1] && (p_cur[W-2:0] == SMP_OFS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            SS_n      <= 1'b1;
            SCLK      <= 1'b1;
            MOSI      <= 1'b0;
            cnv_cmplt <= 1'b0;
            rr        <= '0;
            rx        <= '0;
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            SS_n      <= !in_txn_nxt;
            SCLK      <= sclk_nxt;
            MOSI      <= mosi_nxt;
            cnv_cmplt <= done;
            // Only 12 bits are kept; the upper four shift out and are lost.
            if (sample) rx <= {rx[10:0], miso_smp};
            if (done) begin
                case (rr)
                    2'd0: lft_ld    <= rx;
                    2'd1: rght_ld   <= rx;
                    2'd2: steer_pot <= rx;
                    2'd3: batt      <= rx;
                    default: ;
                endcase
                rr <= rr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_a2d_rr_sampler.sv
// Directed bench for a2d_rr_sampler with a behavioural ADC model and SPI monitor.
module tb_a2d_rr_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        miso = 1'b0;
    logic        SS_n, SCLK, MOSI, cnv_cmplt;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;

    int checks = 0;
    int errors = 0;

    logic [15:0] adc_val = 16'h0000;
    logic [11:0] exp_r [4];
    logic [11:0] got   [4];

    // monitor state
    logic [15:0] mosi_q [$];
    int          gap_q  [$];
    int          rise_err = 0;
    int          idle_err = 0;

    a2d_rr_sampler #(.SCLK_DIV_W(5)) dut (
        .clk(clk), .rst(rst), .nxt(nxt), .MISO(miso),
        .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
        .cnv_cmplt(cnv_cmplt)
    );

    always #5 clk = ~clk;

    // ADC model + SPI checker: mode with SCLK idle high, data out on fall, capture on rise.
    initial begin
        logic        prev_sclk, prev_ssn, read_next, cur_read;
        logic [15:0] drv, mosi_sh;
        int          rises, gap_cnt;
        prev_sclk = 1'b1; prev_ssn = 1'b1; read_next = 1'b0; cur_read = 1'b0;
        drv = '0; mosi_sh = '0; rises = 0; gap_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                read_next = 1'b0;
                miso      = 1'b0;
                prev_sclk = 1'b1;
                prev_ssn  = 1'b1;
                gap_cnt   = 0;
            end else begin
                if (prev_ssn && !SS_n) begin
                    cur_read  = read_next;
                    read_next = !read_next;
                    drv       = cur_read ? adc_val : 16'hFFFF;
                    rises     = 0;
                    mosi_sh   = '0;
                    if (cur_read) gap_q.push_back(gap_cnt);
                end
                if (SS_n && prev_ssn && (SCLK != prev_sclk)) idle_err++;
                if (!SS_n && prev_sclk && !SCLK) begin
                    miso = drv[15];
                    drv  = drv << 1;
                end
                if (!SS_n && !prev_sclk && SCLK) begin
                    mosi_sh = {mosi_sh[14:0], MOSI};
                    rises++;
                end
                if (!prev_ssn && SS_n) begin
                    mosi_q.push_back(mosi_sh);
                    if (rises != 16) rise_err++;
                    gap_cnt = 1;
                end else if (SS_n) begin
                    gap_cnt++;
                end
                prev_sclk = SCLK;
                prev_ssn  = SS_n;
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int unsigned i = 0; i < 4; i++) exp_r[i] = 12'h000;
    endtask

    task automatic run_conv(input logic [15:0] val, output int cyc);
        adc_val = val;
        @(negedge clk) nxt = 1'b1;
        @(negedge clk) nxt = 1'b0;
        cyc = 1;
        while (!cnv_cmplt && cyc < 1300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({SS_n, SCLK, MOSI, cnv_cmplt} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_pins got %b want 1100", {SS_n, SCLK, MOSI, cnv_cmplt});
        end
        checks++;
        if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin
            errors++;
            $display("FAIL reset_regs got %h want 0", {lft_ld, rght_ld, steer_pot, batt});
        end
        rst = 1'b0;
        for (int unsigned i = 0; i < 4; i++) exp_r[i] = 12'h000;
    endtask

    task automatic test_single();
        int base, cyc;
        base = mosi_q.size();
        adc_val = 16'h0A5C;
        @(negedge clk) nxt = 1'b1;
        @(negedge clk) nxt = 1'b0;
        checks++;
        if (SS_n !== 1'b0) begin
            errors++;
            $display("FAIL single_ssn_fall got %b want 0 in cycle 1", SS_n);
        end
        cyc = 1;
        while (!cnv_cmplt && cyc < 1300) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 1105) begin
            errors++;
            $display("FAIL single_latency got %0d want 1105", cyc);
        end
        exp_r[0] = 12'hA5C;
        got = '{lft_ld, rght_ld, steer_pot, batt};
        for (int unsigned i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL single_reg%0d got %h want %h", i, got[i], exp_r[i]);
            end
        end
        checks++;
        if (mosi_q.size() != base + 2 || mosi_q[base] !== 16'h0000 || mosi_q[base+1] !== 16'h0000) begin
            errors++;
            $display("FAIL single_mosi words %0d want 2 x 0000", mosi_q.size() - base);
        end
        @(negedge clk);
        checks++;
        if (cnv_cmplt !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width got %b want 0", cnv_cmplt);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] cmds [5];
        logic [11:0] vals [5];
        int base, cyc;
        cmds = '{16'h0000, 16'h2000, 16'h2800, 16'h3000, 16'h0000};
        vals = '{12'h111, 12'h222, 12'h333, 12'h444, 12'h555};
        apply_reset();
        for (int unsigned k = 0; k < 5; k++) begin
            base = mosi_q.size();
            run_conv({4'h0, vals[k]}, cyc);
            checks++;
            if (cyc != 1105 || mosi_q.size() != base + 2 || mosi_q[base] !== cmds[k]
                || mosi_q[base+1] !== cmds[k]) begin
                errors++;
                $display("FAIL rr_cmd%0d cyc %0d word %h want 1105 %h", k, cyc,
                         (mosi_q.size() > base) ? mosi_q[base] : 16'hxxxx, cmds[k]);
            end
        end
        exp_r = '{12'h555, 12'h222, 12'h333, 12'h444};
        got = '{lft_ld, rght_ld, steer_pot, batt};
        for (int unsigned i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL rr_reg%0d got %h want %h", i, got[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_busy();
        int pulses, cyc;
        apply_reset();
        adc_val = 16'h0ABC;
        pulses = 0;
        repeat (100) @(negedge clk);
        nxt = 1'b1;
        @(negedge clk) nxt = 1'b0;
        for (int c = 1; c < 2400; c++) begin
            if (c == 600) nxt = 1'b1;
            if (c == 601) nxt = 1'b0;
            if (cnv_cmplt) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL busy_pulses got %0d want 1", pulses);
        end
        run_conv(16'h0DEF, cyc);
        exp_r = '{12'hABC, 12'hDEF, 12'h000, 12'h000};
        got = '{lft_ld, rght_ld, steer_pot, batt};
        for (int unsigned i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== exp_r[i]) begin
                errors++;
                $display("FAIL busy_reg%0d got %h want %h", i, got[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_masking();
        int cyc, base;
        base = mosi_q.size();
        run_conv(16'hF123, cyc);
        checks++;
        if (steer_pot !== 12'h123 || mosi_q.size() != base + 2 || mosi_q[base+1] !== 16'h2800) begin
            errors++;
            $display("FAIL mask_steer got %h want 123 (cmd 2800)", steer_pot);
        end
        checks++;
        if (lft_ld !== 12'hABC || rght_ld !== 12'hDEF || batt !== 12'h000) begin
            errors++;
            $display("FAIL mask_others got %h %h %h want abc def 000", lft_ld, rght_ld, batt);
        end
    endtask

    task automatic test_reset_mid();
        int cyc, base;
        adc_val = 16'h0999;
        @(negedge clk) nxt = 1'b1;
        @(negedge clk) nxt = 1'b0;
        repeat (800) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({SS_n, SCLK, MOSI, cnv_cmplt} !== 4'b1100 || {lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin
            errors++;
            $display("FAIL midreset got pins %b regs %h want 1100 0",
                     {SS_n, SCLK, MOSI, cnv_cmplt}, {lft_ld, rght_ld, steer_pot, batt});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base = mosi_q.size();
        run_conv(16'h0BEE, cyc);
        checks++;
        if (lft_ld !== 12'hBEE || {rght_ld, steer_pot, batt} !== 36'h0 || mosi_q[base] !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_next got %h %h want bee 0", lft_ld, {rght_ld, steer_pot, batt});
        end
    endtask

    task automatic test_back_to_back();
        int t [3];
        int n, cyc, g0;
        apply_reset();
        g0 = gap_q.size();
        adc_val = 16'h0777;
        n = 0;
        cyc = 0;
        @(negedge clk) nxt = 1'b1;
        while (n < 3 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cnv_cmplt) begin
                t[n] = cyc;
                n++;
            end
        end
        nxt = 1'b0;
        checks++;
        if (n != 3 || t[0] != 1105 || t[1] - t[0] != 1105 || t[2] - t[1] != 1105) begin
            errors++;
            $display("FAIL b2b_period got n=%0d t=%0d,%0d,%0d want 1105,2210,3315",
                     n, t[0], t[1], t[2]);
        end
        checks++;
        if (gap_q.size() != g0 + 3 || gap_q[g0] != 16 || gap_q[g0+1] != 16 || gap_q[g0+2] != 16) begin
            errors++;
            $display("FAIL b2b_gap got %0d gaps, first %0d want 3 x 16", gap_q.size() - g0,
                     (gap_q.size() > g0) ? gap_q[g0] : -1);
        end
        checks++;
        if (rise_err != 0 || idle_err != 0) begin
            errors++;
            $display("FAIL spi_protocol got rise_err %0d idle_err %0d want 0 0", rise_err, idle_err);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (SS_n !== 1'b1 || lft_ld !== 12'h777 || steer_pot !== 12'h777 || batt !== 12'h000) begin
            errors++;
            $display("FAIL b2b_stop got ssn %b regs %h %h %h want 1 777 777 000",
                     SS_n, lft_ld, steer_pot, batt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_busy();
        test_masking();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
